seg_scan_driver: RTL and testbench

- Time-multiplexed scan driver for the board's six-digit seven-segment display.
- Consumes the 42-bit packed segment word produced by the operation/display-encoding stages and drives one digit at a time through shared segment lines and per-digit enables.
- The input word is captured once per frame into a shadow register, so a frame never mixes old and new digits.
- Each digit slot starts with a programmable blanking interval that suppresses ghosting.

---
 rtl/seg_scan_driver.sv | 95 +++++++++
 tb/tb_seg_scan_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for a six-digit seven-segment display.
// The segment word is latched once per frame, and each digit slot opens with a blanking interval.
module seg_scan_driver #(
    parameter int DIV            = 50000,
    parameter int BLANK          = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [41:0] display,
    output logic [6:0]  seg,
    output logic [5:0]  an,
    output logic [2:0]  digit_idx,
    output logic        frame_start
);

    localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
    localparam logic          SEG_OFF = (SEG_ACTIVE_LOW != 0);
    localparam logic          AN_OFF  = (AN_ACTIVE_LOW != 0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [41:0]   shadow_q, shadow_d;
    logic          frame_start_q, frame_start_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          wrap;
    logic          frame_end;
    logic          lit;
    logic [6:0]    field;
    logic [5:0]    onehot;

    always_comb begin
        wrap          = en && (cnt_q == CNT_MAX);
        frame_end     = wrap && (idx_q == 3'd5);
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        frame_start_d = frame_end;

        if (wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Capture only at the frame boundary so a frame never mixes old and new digits.
        if (frame_end) begin
            shadow_d = display;
        end

        field = '0;
        for (int k = 0; k < 6; k++) begin
            if (idx_q == 3'(k)) begin
                field = shadow_q[7*k +: 7];
            end
        end
        onehot = 6'b000001 << idx_q;

        lit  = en && (cnt_q >= BLANK_C);
        an_d  = lit ? (AN_OFF  ? ~onehot : onehot) : {6{AN_OFF}};
        seg_d = lit ? (SEG_OFF ? ~field  : field)  : {7{SEG_OFF}};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            frame_start_q <= 1'b0;
            an_q          <= {6{AN_OFF}};
            seg_q         <= {7{SEG_OFF}};
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            frame_start_q <= frame_start_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign digit_idx   = idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIV=8, BLANK=2, active-low outputs).
// A frame-position reference model checks every output on every cycle.
module tb_seg_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 6 * DIV;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic [41:0] display = '0;
    logic [6:0]  seg;
    logic [5:0]  an;
    logic [2:0]  digit_idx;
    logic        frame_start;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position within the frame (0..47) plus the latched word.
    int          pos = 0;
    logic [41:0] m_shadow = '0;
    logic        last_fs = 1'b0;

    seg_scan_driver #(
        .DIV(DIV), .BLANK(BLANK), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .display(display),
        .seg(seg), .an(an), .digit_idx(digit_idx), .frame_start(frame_start)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos      = 0;
        m_shadow = '0;
        last_fs  = 1'b0;
    endtask

    // One clock cycle: predict from pre-edge model state, clock, then compare at the falling edge.
    task automatic tick();
        int          d;
        int          c;
        logic        lit;
        logic        eof;
        logic [5:0]  exp_an;
        logic [6:0]  exp_seg;
        d   = pos / DIV;
        c   = pos % DIV;
        lit = en && (c >= BLANK);
        eof = en && (pos == FRAME - 1);
        exp_an  = lit ? ~(6'b000001 << d) : 6'h3F;
        exp_seg = lit ? ~m_shadow[7*d +: 7] : 7'h7F;
        if (en) pos = (pos + 1) % FRAME;
        if (eof) m_shadow = display;
        @(posedge clk);
        @(negedge clk);
        check("an", 64'(an), 64'(exp_an));
        check("seg", 64'(seg), 64'(exp_seg));
        check("frame_start", 64'(frame_start), 64'(eof));
        check("digit_idx", 64'(digit_idx), 64'(pos / DIV));
        last_fs = frame_start;
    endtask

    task automatic wait_fs(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_fs && n < budget);
        check("frame_start_seen", 64'(last_fs), 64'd1);
    endtask

    typedef struct {
        logic [41:0] word;
        int          digit;
        logic [6:0]  exp_seg;
        logic [5:0]  exp_an;
    } vec_t;

    localparam logic [41:0] D1 = {7'h00, 7'h7E, 7'h30, 7'h00, 7'h7E, 7'h6D};
    localparam logic [41:0] D2 = {42{1'b1}};

    initial begin
        vec_t vecs[7];
        int   n;
        int   lit_cycles;
        int   overlaps;

        vecs[0] = '{D1, 0, 7'h12, 6'h3E};
        vecs[1] = '{D1, 1, 7'h01, 6'h3D};
        vecs[2] = '{D1, 2, 7'h7F, 6'h3B};
        vecs[3] = '{D1, 3, 7'h4F, 6'h37};
        vecs[4] = '{D1, 5, 7'h7F, 6'h1F};
        vecs[5] = '{D2, 4, 7'h00, 6'h2F};
        vecs[6] = '{42'h0, 1, 7'h7F, 6'h3D};

        // Reset with the clock stopped.
        #1 rst_n = 1'b0;
        #4;
        check("rst_an", 64'(an), 64'h3F);
        check("rst_seg", 64'(seg), 64'h7F);
        check("rst_frame_start", 64'(frame_start), 64'd0);
        check("rst_digit_idx", 64'(digit_idx), 64'd0);
        display = D1;
        #5 rst_n = 1'b1;
        model_reset();
        clk_run = 1'b1;

        // First frame is dark; frame_start arrives on cycle 48.
        wait_fs(100, n);
        check("first_fs_cycle", 64'(n), 64'(FRAME));

        // Table: each word is captured, then one digit of the following frame is inspected.
        for (int i = 0; i < 7; i++) begin
            display = vecs[i].word;
            wait_fs(100, n);
            for (int k = 0; k < DIV * vecs[i].digit + BLANK + 1; k++) tick();
            check($sformatf("vec%0d_seg", i), 64'(seg), 64'(vecs[i].exp_seg));
            check($sformatf("vec%0d_an", i), 64'(an), 64'(vecs[i].exp_an));
        end

        // Blanking and non-overlap across one full frame.
        display = D2;
        wait_fs(100, n);
        lit_cycles = 0;
        overlaps   = 0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (an != 6'h3F) lit_cycles++;
            if ($countones(~an) > 1) overlaps++;
        end
        check("lit_cycles_per_frame", 64'(lit_cycles), 64'(6 * (DIV - BLANK)));
        check("an_overlaps", 64'(overlaps), 64'd0);

        // Enable dropped at cnt=4 of digit 3 for 10 cycles.
        n = 0;
        while (pos != 3 * DIV + 4 && n < 100) begin
            tick();
            n++;
        end
        en = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("en_low_an", 64'(an), 64'h3F);
        check("en_low_digit", 64'(digit_idx), 64'd3);
        en = 1'b1;
        wait_fs(100, n);
        check("fs_after_resume", 64'(n), 64'(FRAME - (3 * DIV + 4)));

        // Asynchronous reset between edges while digit 4 is lit.
        n = 0;
        while (pos != 4 * DIV + 5 && n < 100) begin
            tick();
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an", 64'(an), 64'h3F);
        check("async_rst_seg", 64'(seg), 64'h7F);
        check("async_rst_digit", 64'(digit_idx), 64'd0);
        check("async_rst_fs", 64'(frame_start), 64'd0);
        model_reset();
        #1 rst_n = 1'b1;
        wait_fs(100, n);
        check("fs_after_async_rst", 64'(n), 64'(FRAME));

        // Randomized enable and display traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) display = {$urandom(), $urandom()} >> 22;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
